// File: rtl/iq_satrnd_pkg.sv
// Shared definitions for the I/Q saturate/round scheduler.
// Contents: default datapath widths, saturation counter width and the ID-width helpers used
// to size requester indices.
package iq_satrnd_pkg;

  localparam int unsigned DEF_IN_SIZE    = 32;
  localparam int unsigned DEF_TRUNC_SIZE = 15;
  localparam int unsigned DEF_OUT_SIZE   = 16;
  localparam int unsigned SAT_CNT_W      = 16;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

  // Requester ID width, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iq_satrnd_sched_sat_rnd.sv
// Dual-channel (I/Q) round-half-up and saturate unit, purely combinational.
// Ports:
//   in_i_i / in_q_i   signed IN_SIZE-bit I and Q samples
//   out_i_o / out_q_o signed OUT_SIZE-bit results: TRUNC_SIZE LSBs dropped with half-up
//                     rounding, then clamped to the OUT_SIZE range
module iq_satrnd_sched_sat_rnd #(
  parameter int unsigned IN_SIZE    = 32,
  parameter int unsigned TRUNC_SIZE = 15,
  parameter int unsigned OUT_SIZE   = 16
) (
  input  logic [IN_SIZE-1:0]  in_i_i,
  input  logic [IN_SIZE-1:0]  in_q_i,
  output logic [OUT_SIZE-1:0] out_i_o,
  output logic [OUT_SIZE-1:0] out_q_o
);

  // One extra bit so the rounding carry can never overflow t.
  localparam int unsigned TW = IN_SIZE - TRUNC_SIZE + 1;

  logic [1:0][IN_SIZE-1:0]  din;
  logic [1:0][OUT_SIZE-1:0] dout;

  assign din     = {in_q_i, in_i_i};
  assign out_i_o = dout[0];
  assign out_q_o = dout[1];

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic          rnd;
    logic [TW-1:0] t;

    if (TRUNC_SIZE > 0) begin : g_rnd
      assign rnd = din[c][TRUNC_SIZE-1];
    end else begin : g_nornd
      assign rnd = 1'b0;
    end

    assign t = {din[c][IN_SIZE-1], din[c][IN_SIZE-1:TRUNC_SIZE]} + TW'(rnd);

    if (TW > OUT_SIZE) begin : g_sat
      logic [TW-OUT_SIZE:0] hi;
      logic                 ovf;
      // In range only when every bit from OUT_SIZE-1 upward matches the sign.
      assign hi      = t[TW-1:OUT_SIZE-1];
      assign ovf     = ~((&hi) | ~(|hi));
      assign dout[c] = ovf ? {t[TW-1], {(OUT_SIZE-1){~t[TW-1]}}} : t[OUT_SIZE-1:0];
    end else begin : g_ext
      assign dout[c] = OUT_SIZE'($signed(t));
    end
  end

  // Bits below the rounding position do not affect the result.
  logic unused_lsb;
  assign unused_lsb = ^{in_i_i, in_q_i};

endmodule

// File: rtl/iq_satrnd_sched.sv
// Round-robin scheduler sharing one I/Q saturate/round datapath among NUM_REQ requesters.
// Pipeline: combinational pick -> stage A (captured I/Q/ID) -> sat_rnd -> stage B (outputs).
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   req_valid/req_ready    per-requester handshake; req_ready is one-hot or zero
//   req_i/req_q            packed requester samples, requester k at [k*IN_SIZE +: IN_SIZE]
//   req_en                 static mask; masked requesters are never granted
//   out_valid/out_ready    result handshake
//   out_i/out_q            rounded/saturated result, out_id source requester
//   out_sat                I or Q of this result saturated
//   sat_cnt_sel/_clr, sat_cnt  per-requester saturation counters, present only when
//                          IQ_SATRND_SAT_CNT_EN is defined; otherwise sat_cnt reads 0
module iq_satrnd_sched
  import iq_satrnd_pkg::*;
#(
  parameter int unsigned  NUM_REQ    = 4,
  parameter int unsigned  IN_SIZE    = DEF_IN_SIZE,
  parameter int unsigned  TRUNC_SIZE = DEF_TRUNC_SIZE,
  parameter int unsigned  OUT_SIZE   = DEF_OUT_SIZE,
  localparam int unsigned ID_W       = id_width(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*IN_SIZE-1:0] req_i,
  input  logic [NUM_REQ*IN_SIZE-1:0] req_q,
  input  logic [NUM_REQ-1:0]         req_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_SIZE-1:0]        out_i,
  output logic [OUT_SIZE-1:0]        out_q,
  output logic [ID_W-1:0]            out_id,
  output logic                       out_sat,
  input  logic [ID_W-1:0]            sat_cnt_sel,
  input  logic                       sat_cnt_clr,
  output logic [SAT_CNT_W-1:0]       sat_cnt
);

  localparam int unsigned TW = IN_SIZE - TRUNC_SIZE + 1;
  localparam int unsigned CW = (TW > OUT_SIZE) ? TW : OUT_SIZE;

  logic [NUM_REQ-1:0]  eligible;
  logic                grant_found;
  logic [ID_W-1:0]     grant_idx;
  logic [NUM_REQ-1:0]  req_ready_w;
  logic [IN_SIZE-1:0]  sel_i, sel_q;
  logic                b_load, a_accept, xfer;

  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic                a_valid_q;
  logic [IN_SIZE-1:0]  a_i_q, a_q_q;
  logic [ID_W-1:0]     a_id_q;

  logic                out_valid_q;
  logic [OUT_SIZE-1:0] out_i_q, out_q_q;
  logic [ID_W-1:0]     out_id_q;
  logic                out_sat_q;

  logic [OUT_SIZE-1:0] rs_i, rs_q;
  logic [1:0]          sat_ch;

  assign eligible = req_valid & req_en;
  assign b_load   = ~out_valid_q | out_ready;
  // Stage A takes a new sample when empty or when it is draining into stage B this cycle.
  assign a_accept = (~a_valid_q | b_load) & ~reset;
  assign xfer     = grant_found & a_accept;

  // First eligible requester at or after the pointer, wrapping.
  always_comb begin : p_pick
    logic [ID_W-1:0] idx_w;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx_w       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx_w = ID_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!grant_found && eligible[idx_w]) begin
        grant_found = 1'b1;
        grant_idx   = idx_w;
      end
    end
  end

  always_comb begin
    req_ready_w = '0;
    if (xfer) begin
      req_ready_w[grant_idx] = 1'b1;
    end
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_comb begin
    sel_i = '0;
    sel_q = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == ID_W'(k)) begin
        sel_i = req_i[k*IN_SIZE +: IN_SIZE];
        sel_q = req_q[k*IN_SIZE +: IN_SIZE];
      end
    end
  end

  iq_satrnd_sched_sat_rnd #(
    .IN_SIZE    (IN_SIZE),
    .TRUNC_SIZE (TRUNC_SIZE),
    .OUT_SIZE   (OUT_SIZE)
  ) u_sat_rnd (
    .in_i_i  (a_i_q),
    .in_q_i  (a_q_q),
    .out_i_o (rs_i),
    .out_q_o (rs_q)
  );

  // Saturation flag: the narrowed result no longer equals the rounded value t.
  logic [1:0][IN_SIZE-1:0]  a_vec;
  logic [1:0][OUT_SIZE-1:0] rs_vec;
  assign a_vec  = {a_q_q, a_i_q};
  assign rs_vec = {rs_q, rs_i};

  for (genvar c = 0; c < 2; c++) begin : g_satchk
    logic          rnd;
    logic [TW-1:0] t;
    if (TRUNC_SIZE > 0) begin : g_rnd
      assign rnd = a_vec[c][TRUNC_SIZE-1];
    end else begin : g_nornd
      assign rnd = 1'b0;
    end
    assign t         = {a_vec[c][IN_SIZE-1], a_vec[c][IN_SIZE-1:TRUNC_SIZE]} + TW'(rnd);
    assign sat_ch[c] = CW'($signed(t)) != CW'($signed(rs_vec[c]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      a_valid_q   <= 1'b0;
      a_i_q       <= '0;
      a_q_q       <= '0;
      a_id_q      <= '0;
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_id_q    <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (xfer) begin
        a_valid_q <= 1'b1;
        a_i_q     <= sel_i;
        a_q_q     <= sel_q;
        a_id_q    <= grant_idx;
      end else if (b_load) begin
        a_valid_q <= 1'b0;
      end
      if (b_load) begin
        out_valid_q <= a_valid_q;
        out_i_q     <= rs_i;
        out_q_q     <= rs_q;
        out_id_q    <= a_id_q;
        out_sat_q   <= |sat_ch;
      end
    end
  end

  assign req_ready = req_ready_w;
  assign out_valid = out_valid_q;
  assign out_i     = out_i_q;
  assign out_q     = out_q_q;
  assign out_id    = out_id_q;
  assign out_sat   = out_sat_q;

`ifdef IQ_SATRND_SAT_CNT_EN
  logic [NUM_REQ-1:0][SAT_CNT_W-1:0] cnt_q, cnt_d;
  logic [SAT_CNT_W-1:0]              sat_cnt_q, sat_cnt_d;

  always_comb begin
    cnt_d     = cnt_q;
    sat_cnt_d = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (sat_cnt_clr) begin
        cnt_d[k] = '0;
      end else if (out_valid_q && out_ready && out_sat_q && (out_id_q == ID_W'(k)) &&
                   (cnt_q[k] != '1)) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
      if (sat_cnt_sel == ID_W'(k)) begin
        sat_cnt_d = cnt_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      sat_cnt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;
`else
  assign sat_cnt = '0;

  logic unused_cnt;
  assign unused_cnt = ^{sat_cnt_sel, sat_cnt_clr};
`endif

endmodule

// File: tb/tb_iq_satrnd_sched.sv
// Self-checking bench for iq_satrnd_sched (NUM_REQ=4, 32 -> 16 bits, 15 LSBs rounded off).
// A transaction-level model (integer rounding/clamping, round-robin pick, two-slot pipeline)
// predicts every handshake and result each clock.
module tb_iq_satrnd_sched;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned IN_SIZE  = 32;
  localparam int unsigned OUT_SIZE = 16;
  localparam int unsigned ID_W     = 2;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [NUM_REQ-1:0]         req_valid, req_ready, req_en;
  logic [NUM_REQ*IN_SIZE-1:0] req_i, req_q;
  logic                       out_valid, out_ready;
  logic [OUT_SIZE-1:0]        out_i, out_q;
  logic [ID_W-1:0]            out_id;
  logic                       out_sat;
  logic [ID_W-1:0]            sat_cnt_sel;
  logic                       sat_cnt_clr;
  logic [15:0]                sat_cnt;

  iq_satrnd_sched #(
    .NUM_REQ    (4),
    .IN_SIZE    (32),
    .TRUNC_SIZE (15),
    .OUT_SIZE   (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_i       (req_i),
    .req_q       (req_q),
    .req_en      (req_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_i       (out_i),
    .out_q       (out_q),
    .out_id      (out_id),
    .out_sat     (out_sat),
    .sat_cnt_sel (sat_cnt_sel),
    .sat_cnt_clr (sat_cnt_clr),
    .sat_cnt     (sat_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int xfers  = 0;
  int got_ids[$];

  // Model state: pointer, stage contents, counters.
  int unsigned m_ptr = 0;
  bit          ma_v = 1'b0, mb_v = 1'b0;
  logic [31:0] ma_i = '0, ma_q = '0, mb_i = '0, mb_q = '0;
  int unsigned ma_id = 0, mb_id = 0;
  int unsigned m_cnt[NUM_REQ];
  int unsigned m_sat_cnt = 0;

  // {sat, value}: round(d / 2^15) half-up, then clamp to int16.
  function automatic logic [16:0] ref_rs(input logic [31:0] d);
    longint t;
    t = (longint'($signed(d)) + 64'sd16384) >>> 15;
    if (t > 32767) return {1'b1, 16'h7fff};
    if (t < -32768) return {1'b1, 16'h8000};
    return {1'b0, t[15:0]};
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] bnd[6];
    bnd = '{32'h3fffbfff, 32'h3fffc000, 32'hbfffc000, 32'hbfffbfff, 32'h7fffffff, 32'h80000000};
    case ($urandom_range(0, 3))
      0:       return bnd[$urandom_range(0, 5)];
      1:       return 32'($urandom_range(0, 65535)) - 32'd32768;
      default: return $urandom();
    endcase
  endfunction

  task automatic rand_data();
    for (int k = 0; k < NUM_REQ; k++) begin
      req_i[k*IN_SIZE +: IN_SIZE] = pick();
      req_q[k*IN_SIZE +: IN_SIZE] = pick();
    end
  endtask

  task automatic set_req(input int k, input logic [31:0] di, input logic [31:0] dq);
    req_i[k*IN_SIZE +: IN_SIZE] = di;
    req_q[k*IN_SIZE +: IN_SIZE] = dq;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs applied; checks, advances one clock,
  // returns on the next falling edge.
  task automatic step();
    logic [NUM_REQ-1:0] elig, exp_rdy;
    logic [16:0]        ri, rq;
    bit                 b_load, xfer;
    int                 g;
    int unsigned        idx;
    #1;
    elig   = req_valid & req_en;
    b_load = !mb_v || out_ready;
    g      = -1;
    if (!reset && (!ma_v || b_load)) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (g < 0 && elig[idx]) g = int'(idx);
      end
    end
    xfer    = (g >= 0);
    exp_rdy = '0;
    if (xfer) exp_rdy[g] = 1'b1;
    ri = ref_rs(mb_i);
    rq = ref_rs(mb_q);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(mb_v));
    if (mb_v) begin
      chk("out_i", 32'(out_i), 32'(ri[15:0]));
      chk("out_q", 32'(out_q), 32'(rq[15:0]));
      chk("out_id", 32'(out_id), mb_id);
      chk("out_sat", 32'(out_sat), 32'(ri[16] | rq[16]));
    end
`ifdef IQ_SATRND_SAT_CNT_EN
    chk("sat_cnt", 32'(sat_cnt), m_sat_cnt);
`else
    chk("sat_cnt_off", 32'(sat_cnt), 32'd0);
`endif
    if (!reset && (req_valid & req_ready) != '0) xfers++;
    if (!reset && out_valid && out_ready) got_ids.push_back(int'(out_id));
    @(posedge clk);
    if (reset) begin
      m_ptr     = 0;
      ma_v      = 1'b0;
      mb_v      = 1'b0;
      m_sat_cnt = 0;
      foreach (m_cnt[k]) m_cnt[k] = 0;
    end else begin
      m_sat_cnt = m_cnt[sat_cnt_sel];
      if (sat_cnt_clr) begin
        foreach (m_cnt[k]) m_cnt[k] = 0;
      end else if (mb_v && out_ready && (ri[16] | rq[16]) && m_cnt[mb_id] < 65535) begin
        m_cnt[mb_id]++;
      end
      if (b_load) begin
        mb_v  = ma_v;
        mb_i  = ma_i;
        mb_q  = ma_q;
        mb_id = ma_id;
      end
      if (xfer) begin
        ma_v  = 1'b1;
        ma_i  = req_i[g*IN_SIZE +: IN_SIZE];
        ma_q  = req_q[g*IN_SIZE +: IN_SIZE];
        ma_id = g;
        m_ptr = (g + 1) % NUM_REQ;
      end else if (b_load) begin
        ma_v = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [OUT_SIZE-1:0] h_i, h_q;
    logic [ID_W-1:0]     h_id;
    foreach (m_cnt[k]) m_cnt[k] = 0;
    reset       = 1'b1;
    req_valid   = '1;
    req_en      = '1;
    out_ready   = 1'b1;
    req_i       = '0;
    req_q       = '0;
    sat_cnt_sel = '0;
    sat_cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, with every requester asking.
    step();
    chk("rst_out_i", 32'(out_i), 32'd0);
    chk("rst_out_q", 32'(out_q), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);

    // Half-up rounding, including -0.5 -> 0.
    reset     = 1'b0;
    req_valid = 4'b0001;
    set_req(0, 32'h00004000, 32'hffffc000);
    step();
    req_valid = '0;
    step();
    chk("round_valid", 32'(out_valid), 32'd1);
    chk("round_i", 32'(out_i), 32'h0001);
    chk("round_q", 32'(out_q), 32'h0000);
    chk("round_id", 32'(out_id), 32'd0);
    chk("round_sat", 32'(out_sat), 32'd0);

    // Positive and negative full-scale saturation.
    set_req(2, 32'h7fffffff, 32'h80000000);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    step();
    chk("sat_valid", 32'(out_valid), 32'd1);
    chk("sat_i", 32'(out_i), 32'h7fff);
    chk("sat_q", 32'(out_q), 32'h8000);
    chk("sat_flag", 32'(out_sat), 32'd1);
    chk("sat_id", 32'(out_id), 32'd2);

    // Fairness, all enabled.
    reset = 1'b1;
    step();
    reset = 1'b0;
    got_ids.delete();
    req_valid = '1;
    repeat (10) begin
      rand_data();
      step();
    end
    chk("fair_cnt", 32'(got_ids.size()), 32'd8);
    for (int k = 0; k < 8 && k < got_ids.size(); k++) chk("fair_id", got_ids[k], k % 4);

    // Fairness with requesters 0 and 2 masked.
    reset = 1'b1;
    step();
    reset  = 1'b0;
    req_en = 4'b1010;
    got_ids.delete();
    repeat (10) begin
      rand_data();
      step();
    end
    chk("mask_cnt", 32'(got_ids.size()), 32'd8);
    for (int k = 0; k < 8 && k < got_ids.size(); k++) chk("mask_id", got_ids[k], (k % 2) ? 3 : 1);

    // Backpressure: two transfers fill the pipe, then everything holds.
    reset  = 1'b1;
    req_en = '1;
    step();
    reset     = 1'b0;
    out_ready = 1'b0;
    xfers     = 0;
    rand_data();
    step();
    step();
    h_i  = out_i;
    h_q  = out_q;
    h_id = out_id;
    repeat (3) begin
      step();
      chk("bp_hold_v", 32'(out_valid), 32'd1);
      chk("bp_hold_i", 32'(out_i), 32'(h_i));
      chk("bp_hold_q", 32'(out_q), 32'(h_q));
      chk("bp_hold_id", 32'(out_id), 32'(h_id));
    end
    chk("bp_xfers", 32'(xfers), 32'd2);
    chk("bp_ready", 32'(req_ready), 32'd0);
    got_ids.delete();
    out_ready = 1'b1;
    req_valid = '0;
    repeat (4) step();
    chk("bp_drain_cnt", 32'(got_ids.size()), 32'd2);
    if (got_ids.size() == 2) begin
      chk("bp_drain_id0", got_ids[0], 0);
      chk("bp_drain_id1", got_ids[1], 1);
    end
    chk("bp_drain_v", 32'(out_valid), 32'd0);

    // Reset with both stages full; pointer is left at 2 beforehand.
    out_ready = 1'b0;
    req_valid = 4'b0110;
    rand_data();
    repeat (3) step();
    chk("full_valid", 32'(out_valid), 32'd1);
    chk("full_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    req_valid = '1;
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'b0001);
    step();

`ifdef IQ_SATRND_SAT_CNT_EN
    // Three saturating results from requester 1, then clear.
    reset = 1'b1;
    step();
    reset       = 1'b0;
    sat_cnt_sel = 2'd1;
    set_req(1, 32'h7fffffff, 32'h00000000);
    req_valid = 4'b0010;
    repeat (3) step();
    req_valid = '0;
    repeat (4) step();
    chk("cnt_three", 32'(sat_cnt), 32'd3);
    sat_cnt_clr = 1'b1;
    step();
    sat_cnt_clr = 1'b0;
    step();
    chk("cnt_clear", 32'(sat_cnt), 32'd0);
`endif

    // Random traffic, masks, backpressure, clears and occasional resets.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int n = 0; n < 400; n++) begin
      req_valid   = NUM_REQ'($urandom());
      req_en      = ($urandom_range(0, 3) == 0) ? NUM_REQ'($urandom()) : '1;
      out_ready   = ($urandom_range(0, 3) != 0);
      sat_cnt_sel = ID_W'($urandom());
      sat_cnt_clr = ($urandom_range(0, 31) == 0);
      reset       = ($urandom_range(0, 99) == 0);
      rand_data();
      step();
    end
    reset       = 1'b0;
    req_valid   = '0;
    out_ready   = 1'b1;
    sat_cnt_clr = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iq_satrnd_sched.md
Name: iq_satrnd_sched

Overview:
- Round-robin scheduler that shares one dual-channel (I/Q) saturate/round datapath among NUM_REQ streaming requesters, for example the per-stage decimator/mixer outputs of the medium-wave receiver.
- Arbitrates valid/ready requests and feeds the winner's I/Q pair through a 2-stage pipeline.
- Returns the scaled result tagged with the requester ID, plus a saturation flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- IN_SIZE, 32, signed input width per component.
- TRUNC_SIZE, 15, LSBs truncated (0 allowed: no rounding).
- OUT_SIZE, 16, signed output width per component.
- ID_W, derived = max(1, ceil(log2(NUM_REQ))), requester ID width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester data valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_i  in  NUM_REQ*IN_SIZE  packed I inputs, requester k at [k*IN_SIZE +: IN_SIZE]
- req_q  in  NUM_REQ*IN_SIZE  packed Q inputs, same packing
- req_en  in  NUM_REQ  static enable mask; disabled requesters are never granted
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_i  out  OUT_SIZE  rounded/saturated I
- out_q  out  OUT_SIZE  rounded/saturated Q
- out_id  out  ID_W  requester index of the result
- out_sat  out  1  I or Q saturated for this result
- sat_cnt_sel  in  ID_W  counter readback select (optional feature)
- sat_cnt_clr  in  1  clear all saturation counters (optional feature)
- sat_cnt  out  16  selected saturation counter (optional feature)

Behaviour:
- Reset (synchronous, active-high): out_valid=0, out_i=0, out_q=0, out_id=0, out_sat=0, req_ready=0, pointer=0, stage-A valid=0, counters=0. Reset mid-transfer discards in-flight data with no output.
- Arbitration (combinational):
  - eligible = req_valid & req_en.
  - Grant the first eligible index at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready[g]=1 only when stage A can accept (stage A empty, or stage A advancing this cycle). All other req_ready bits are 0.
  - A transfer is req_valid[g] & req_ready[g]. On a transfer the pointer becomes (g+1) mod NUM_REQ. The pointer is unchanged otherwise.
- Stage A (register): captures I, Q and ID of the granted requester.
- Stage B (output register) loads round/saturate(stage A) when out_valid=0 or out_ready=1.
- Latency: 2 clocks from transfer to out_valid. Throughput: 1 result per clock when out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, out_* are held stable and stage A holds. A full pipeline drops all req_ready to 0.
- Arithmetic per component:
  - t = sign-extend(d[IN_SIZE-1:TRUNC_SIZE]) + d[TRUNC_SIZE-1], width IN_SIZE-TRUNC_SIZE+1. Rounding is half-up, so -0.5 rounds to 0.
  - If the bits of t above OUT_SIZE-1 are not all equal to the sign of t, saturate: output = {sign, (OUT_SIZE-1) copies of ~sign}.
  - Otherwise output = t[OUT_SIZE-1:0].
  - out_sat = sat_I | sat_Q.
- Boundaries:
  - req_valid deasserted without a transfer: no state change.
  - No eligible requester: no grant, pointer held.
  - Requester disabled while it is in flight: its data still completes.
  - A transfer and an output pop in the same cycle are both honoured.

Optional Feature:
- Macro: IQ_SATRND_SAT_CNT_EN.
- Defined:
  - One 16-bit counter per requester, incremented when a result with out_sat=1 is accepted (out_valid & out_ready), attributed to out_id.
  - Counters stick at 0xFFFF.
  - sat_cnt_clr zeroes all counters, with priority over an increment in the same cycle.
  - sat_cnt = counter[sat_cnt_sel], registered (1-clock latency). sat_cnt_sel >= NUM_REQ returns 0.
- Undefined: counters absent, sat_cnt tied to 0, sat_cnt_sel and sat_cnt_clr ignored.

Decomposition:
- Shared package iq_satrnd_pkg holds:
  - ID width function clog2.
  - Default width constants IN_SIZE/TRUNC_SIZE/OUT_SIZE (32/15/16).
  - SAT_CNT_W=16.
- One sub-module: the existing dual-channel sat_rnd combinational unit, instantiated once between stage A and stage B. Its saturation-detect result is recomputed locally for out_sat.
- The round-robin picker stays inline.

Test Plan (NUM_REQ=4, IN_SIZE=32, TRUNC_SIZE=15, OUT_SIZE=16):
- Rounding: req 0 I=0x00004000, Q=0xFFFFC000, out_ready=1 -> 2 clocks later out_i=0x0001, out_q=0x0000, out_id=0, out_sat=0.
- Saturation: req 2 I=0x7FFFFFFF, Q=0x80000000 -> out_i=0x7FFF, out_q=0x8000, out_sat=1, out_id=2.
- Fairness: all 4 valid continuously, req_en=4'b1111, out_ready=1 -> out_id sequence 0,1,2,3,0,1,… one per clock. With req_en=4'b1010 -> 1,3,1,3.
- Backpressure: out_ready=0 for 5 clocks with all requesters valid -> exactly 2 transfers accepted, then req_ready=0. out_* stable throughout. On release, no result is lost or duplicated.
- Reset mid-stream: assert reset with both stages full -> next clock out_valid=0 and pointer=0; the first grant after reset goes to requester 0.
- With IQ_SATRND_SAT_CNT_EN: 3 saturating results from req 1, sat_cnt_sel=1 -> sat_cnt=3. Pulse sat_cnt_clr -> sat_cnt=0.
